// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states
// and the datapath select/operation codes driven by the controller.
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXEC    = 4'd6,
    ST_RTYPEWB = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JUMP    = 4'd11,
    ST_ERROR   = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] NE_BEQ = 2'b00;
  localparam logic [1:0] NE_BNE = 2'b01;

  // States that wait on the memory handshake and are guarded by the timeout.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wait_timer.sv
// Saturating count of consecutive memory-wait cycles; expired flags the last
// allowed wait cycle. WAIT_LIMIT of 0 disables expiry entirely.
`default_nettype none

module wait_timer #(
  parameter int WAIT_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);
  localparam logic [CW-1:0] LAST  = CW'(WAIT_LIMIT - 1);
  localparam logic ENABLED = (WAIT_LIMIT > 0);

  logic [CW-1:0] count;

  // Saturates at LIMIT so a long stall can never wrap back below LAST.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = ENABLED && (count == LAST);

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath with a memory-wait timeout
// that traps into a sticky ERROR state.
`default_nettype none

module multicycle_control
  import mips_pkg::*;
#(
  parameter int WAIT_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [1:0] ne,
  output logic       err
);

  state_t state;
  state_t next_state;
  logic   stalled;
  logic   timer_expired;

  assign stalled = is_wait_state(state) && !mem_ready;

  // Clearing whenever not stalled guarantees a zero count on wait-state entry.
  wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!stalled),
    .inc     (stalled),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH, ST_MEMRD, ST_MEMWR: begin
        if (mem_ready) begin
          case (state)
            ST_FETCH: next_state = ST_DECODE;
            ST_MEMRD: next_state = ST_MEMWB;
            default:  next_state = ST_FETCH;
          endcase
        end else if (timer_expired) begin
          next_state = ST_ERROR;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:      next_state = ST_EXEC;
          OP_LW, OP_SW:  next_state = ST_MEMADR;
          OP_BEQ, OP_BNE: next_state = ST_BRANCH;
          OP_ADDI:       next_state = ST_ADDIEX;
          OP_J:          next_state = ST_JUMP;
          default:       next_state = ST_ERROR;
        endcase
      end
      ST_MEMADR:  next_state = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMWB:   next_state = ST_FETCH;
      ST_EXEC:    next_state = ST_RTYPEWB;
      ST_RTYPEWB: next_state = ST_FETCH;
      ST_BRANCH:  next_state = ST_FETCH;
      ST_ADDIEX:  next_state = ST_ADDIWB;
      ST_ADDIWB:  next_state = ST_FETCH;
      ST_JUMP:    next_state = ST_FETCH;
      ST_ERROR:   next_state = ST_ERROR;
      default:    next_state = ST_ERROR;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    ne            = NE_BEQ;
    err           = 1'b0;
    // Outputs are held at zero for as long as reset is asserted.
    if (reset) begin
      case (state)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        ST_DECODE: alu_src_b = SRCB_IMM_SH2;
        ST_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        ST_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        ST_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        ST_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        ST_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        ST_RTYPEWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          ne            = {1'b0, opcode[0]};
        end
        ST_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        ST_ADDIWB: reg_write = 1'b1;
        ST_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        ST_ERROR: err = 1'b1;
        default: err = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: every instruction class,
// memory wait stretching, timeout trap, illegal opcode and reset behaviour.
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a, err;
  logic [1:0] alu_src_b, alu_op, pc_source, ne;

  int passed = 0;
  int total  = 0;

  multicycle_control #(
    .WAIT_LIMIT(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .ne            (ne),
    .err           (err)
  );

  always #5 clk = ~clk;

  logic [18:0] outs;
  assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
                 pc_source, ne, err};

  function automatic logic [18:0] ctl(
    input logic pw, input logic pwc, input logic iod, input logic mr,
    input logic mw, input logic irw, input logic m2r, input logic rw,
    input logic rd, input logic asa, input logic [1:0] asb, input logic [1:0] aop,
    input logic [1:0] psrc, input logic [1:0] nev, input logic e);
    return {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, asa, asb, aop, psrc, nev, e};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // One clock cycle: drive inputs just after the rising edge, check mid-cycle.
  task automatic step(input logic rst_n, input logic rdy, input logic [5:0] op,
                      input string tag, input logic [18:0] exp);
    @(posedge clk);
    #1;
    reset = rst_n;
    mem_ready = rdy;
    opcode = op;
    @(negedge clk);
    check(tag, {13'd0, outs}, {13'd0, exp});
  endtask

  logic [18:0] ZERO, F1, F0, DEC, MADR, MRD, MWB, MWR, EXE, RWB, BNE_V, BEQ_V;
  logic [18:0] AEX, AWB, JMP, ERR;

  initial begin
    //          pw pwc iod mr mw irw m2r rw rd asa asb    aop    psrc   ne     e
    ZERO  = ctl(0, 0,  0,  0, 0, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 2'b00, 0);
    F1    = ctl(1, 0,  0,  1, 0, 1,  0,  0, 0, 0,  2'b01, 2'b00, 2'b00, 2'b00, 0);
    F0    = ctl(0, 0,  0,  1, 0, 0,  0,  0, 0, 0,  2'b01, 2'b00, 2'b00, 2'b00, 0);
    DEC   = ctl(0, 0,  0,  0, 0, 0,  0,  0, 0, 0,  2'b11, 2'b00, 2'b00, 2'b00, 0);
    MADR  = ctl(0, 0,  0,  0, 0, 0,  0,  0, 0, 1,  2'b10, 2'b00, 2'b00, 2'b00, 0);
    MRD   = ctl(0, 0,  1,  1, 0, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 2'b00, 0);
    MWB   = ctl(0, 0,  0,  0, 0, 0,  1,  1, 0, 0,  2'b00, 2'b00, 2'b00, 2'b00, 0);
    MWR   = ctl(0, 0,  1,  0, 1, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 2'b00, 0);
    EXE   = ctl(0, 0,  0,  0, 0, 0,  0,  0, 0, 1,  2'b00, 2'b10, 2'b00, 2'b00, 0);
    RWB   = ctl(0, 0,  0,  0, 0, 0,  0,  1, 1, 0,  2'b00, 2'b00, 2'b00, 2'b00, 0);
    BNE_V = ctl(0, 1,  0,  0, 0, 0,  0,  0, 0, 1,  2'b00, 2'b01, 2'b01, 2'b01, 0);
    BEQ_V = ctl(0, 1,  0,  0, 0, 0,  0,  0, 0, 1,  2'b00, 2'b01, 2'b01, 2'b00, 0);
    AEX   = ctl(0, 0,  0,  0, 0, 0,  0,  0, 0, 1,  2'b10, 2'b00, 2'b00, 2'b00, 0);
    AWB   = ctl(0, 0,  0,  0, 0, 0,  0,  1, 0, 0,  2'b00, 2'b00, 2'b00, 2'b00, 0);
    JMP   = ctl(1, 0,  0,  0, 0, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b10, 2'b00, 0);
    ERR   = ctl(0, 0,  0,  0, 0, 0,  0,  0, 0, 0,  2'b00, 2'b00, 2'b00, 2'b00, 1);

    step(0, 1, 6'b100011, "reset_zero0", ZERO);
    step(0, 1, 6'b100011, "reset_zero1", ZERO);

    // lw: five cycles, writeback only in the fifth
    step(1, 1, 6'b100011, "lw_fetch",  F1);
    step(1, 1, 6'b100011, "lw_decode", DEC);
    step(1, 1, 6'b100011, "lw_memadr", MADR);
    step(1, 1, 6'b100011, "lw_memrd",  MRD);
    step(1, 1, 6'b100011, "lw_memwb",  MWB);

    // bne
    step(1, 1, 6'b000101, "bne_fetch",  F1);
    step(1, 1, 6'b000101, "bne_decode", DEC);
    step(1, 1, 6'b000101, "bne_branch", BNE_V);

    // sw with three wait cycles
    step(1, 1, 6'b101011, "sw_fetch",  F1);
    step(1, 1, 6'b101011, "sw_decode", DEC);
    step(1, 1, 6'b101011, "sw_memadr", MADR);
    step(1, 0, 6'b101011, "sw_memwr0", MWR);
    step(1, 0, 6'b101011, "sw_memwr1", MWR);
    step(1, 0, 6'b101011, "sw_memwr2", MWR);
    step(1, 1, 6'b101011, "sw_memwr3", MWR);

    // R-type
    step(1, 1, 6'b000000, "r_fetch",  F1);
    step(1, 1, 6'b000000, "r_decode", DEC);
    step(1, 1, 6'b000000, "r_exec",   EXE);
    step(1, 1, 6'b000000, "r_wb",     RWB);

    // addi
    step(1, 1, 6'b001000, "addi_fetch",  F1);
    step(1, 1, 6'b001000, "addi_decode", DEC);
    step(1, 1, 6'b001000, "addi_ex",     AEX);
    step(1, 1, 6'b001000, "addi_wb",     AWB);

    // beq
    step(1, 1, 6'b000100, "beq_fetch",  F1);
    step(1, 1, 6'b000100, "beq_decode", DEC);
    step(1, 1, 6'b000100, "beq_branch", BEQ_V);

    // j
    step(1, 1, 6'b000010, "j_fetch",  F1);
    step(1, 1, 6'b000010, "j_decode", DEC);
    step(1, 1, 6'b000010, "j_jump",   JMP);

    // illegal opcode traps and stays trapped
    step(1, 1, 6'b111111, "ill_fetch",  F1);
    step(1, 1, 6'b111111, "ill_decode", DEC);
    step(1, 1, 6'b111111, "ill_error0", ERR);
    step(1, 0, 6'b111111, "ill_error1", ERR);
    step(1, 1, 6'b000000, "ill_error2", ERR);
    step(0, 1, 6'b000000, "ill_reset",  ZERO);

    // mem_ready on the last allowed wait cycle wins over the timeout
    for (int i = 0; i < 7; i++) step(1, 0, 6'b000010, "edge_fetch_wait", F0);
    step(1, 1, 6'b000010, "edge_fetch_ready", F1);
    step(1, 1, 6'b000010, "edge_decode",      DEC);
    step(1, 1, 6'b000010, "edge_jump",        JMP);

    // timeout in FETCH: eight low cycles, ERROR on the ninth
    for (int i = 0; i < 8; i++) step(1, 0, 6'b000000, "to_fetch_wait", F0);
    step(1, 0, 6'b000000, "to_error",        ERR);
    step(1, 1, 6'b000000, "to_error_sticky", ERR);
    step(0, 1, 6'b100011, "to_reset_zero",   ZERO);

    // reset mid-MEMRD: back to FETCH, no writeback
    step(1, 1, 6'b100011, "rmid_fetch",  F1);
    step(1, 1, 6'b100011, "rmid_decode", DEC);
    step(1, 1, 6'b100011, "rmid_memadr", MADR);
    step(1, 0, 6'b100011, "rmid_memrd",  MRD);
    step(0, 1, 6'b100011, "rmid_reset",  ZERO);
    step(1, 1, 6'b000010, "rmid_fetch2", F1);
    check("rmid_no_regwrite", {31'd0, reg_write}, 32'd0);
    step(1, 1, 6'b000010, "rmid_decode2", DEC);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 8: maximum consecutive mem_ready-low cycles per memory wait; 0 disables the timeout.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 opcode  in  6  instruction opcode from datapath IR, stable outside FETCH.
REQ-005 mem_ready  in  1  memory handshake: current access completes this cycle.
REQ-006 pc_write  out  1  unconditional PC load.
REQ-007 pc_write_cond  out  1  PC load qualified by datapath zero/ne.
REQ-008 i_or_d  out  1  memory address select (0 PC, 1 ALUOut).
REQ-009 mem_read  out  1  memory read request.
REQ-010 mem_write  out  1  memory write request.
REQ-011 ir_write  out  1  IR load.
REQ-012 mem_to_reg  out  1  writeback source (1 MDR).
REQ-013 reg_write  out  1  register file write.
REQ-014 reg_dst  out  1  destination select (1 rd, 0 rt).
REQ-015 alu_src_a  out  1  ALU A (0 PC, 1 rs).
REQ-016 alu_src_b  out  2  ALU B (00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2).
REQ-017 alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
REQ-018 pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target.
REQ-019 ne  out  2  branch sense: 00 beq (zero), 01 bne (not zero); 1x reserved, never driven.
REQ-020 err  out  1  sticky fault flag.

Function
REQ-021 SHALL be a Moore FSM; outputs decode from the state register only, except pc_write/ir_write in FETCH, qualified by mem_ready. Outputs not listed for a state SHALL be 0.
REQ-022 FETCH: mem_read=1, alu_src_b=01; ir_write=pc_write=mem_ready; remain until mem_ready=1, then DECODE.
REQ-023 DECODE: alu_src_b=11; next by opcode: 000000->EXEC, 100011/101011->MEMADR, 000100/000101->BRANCH, 001000->ADDIEX, 000010->JUMP, other->ERROR.
REQ-024 MEMADR: alu_src_a=1, alu_src_b=10; ->MEMRD (lw) or MEMWR (sw).
REQ-025 MEMRD: mem_read=1, i_or_d=1; hold until mem_ready, then MEMWB. MEMWB: reg_write=1, mem_to_reg=1; ->FETCH.
REQ-026 MEMWR: mem_write=1, i_or_d=1; hold until mem_ready, then FETCH.
REQ-027 EXEC: alu_src_a=1, alu_op=10; ->RTYPEWB: reg_write=1, reg_dst=1; ->FETCH.
REQ-028 BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, ne={1'b0,opcode[0]}; ->FETCH.
REQ-029 ADDIEX: alu_src_a=1, alu_src_b=10; ->ADDIWB: reg_write=1; ->FETCH.
REQ-030 JUMP: pc_write=1, pc_source=10; ->FETCH.
REQ-031 ERROR: err=1, all else 0; absorbing until reset.
REQ-032 Latency with mem_ready tied high: j/beq/bne 3 cycles; R-type/addi/sw 4; lw 5.
REQ-033 Wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR and increment each wait-state cycle with mem_ready=0; mem_ready=0 with count==WAIT_LIMIT-1 SHALL go to ERROR next cycle; mem_ready=1 on that cycle wins.
REQ-034 Counter width SHALL be $clog2(WAIT_LIMIT+1), no wrap; WAIT_LIMIT=0 SHALL never time out.

Reset
REQ-035 While reset=0, all outputs SHALL be 0; on a clock edge with reset=0, state<=FETCH, counter<=0, err cleared, including mid-instruction or mid-wait.
REQ-036 First cycle after reset release SHALL be FETCH with mem_read=1.

Structure
REQ-037 Opcode constants, 4-bit state encoding, alu_op/alu_src_b/pc_source/ne encodings SHALL live in shared package mips_pkg.
REQ-038 The timeout counter SHALL be sub-module wait_timer (clear, inc, expired); FSM and output decode remain in multicycle_control.

Verification
REQ-039 mem_ready=1; opcode=100011 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1,mem_to_reg=1 only in 5th cycle.
REQ-040 opcode=000101 -> BRANCH cycle 3: pc_write_cond=1, ne=01, pc_source=01, alu_op=01; FETCH on cycle 4.
REQ-041 opcode=101011, mem_ready low 3 cycles in MEMWR -> mem_write=1, i_or_d=1 for 4 cycles, then FETCH.
REQ-042 WAIT_LIMIT=8, mem_ready=0 in FETCH -> err=1 on 9th cycle, sticky; reset=0 clears err, outputs 0.
REQ-043 opcode=111111 -> ERROR after DECODE; reset=0 asserted during MEMRD -> FETCH after release, no reg_write pulse.
